// File: rtl/fmps_capture_pkg.sv
// Shared constants, state encoding and CSR packing for the FMPS capture writer.
// Pure declarations; no timing or flow-control behaviour of its own.
package fmps_capture_pkg;

  localparam int CSR_ACTIVE_BIT  = 31;
  localparam int CSR_VALID_BIT   = 30;
  localparam int CSR_DUP_BIT     = 29;
  localparam int CSR_STRAY_BIT   = 28;
  localparam int CSR_TIMEOUT_BIT = 27;
  localparam int CSR_COUNT_LSB   = 16;
  localparam int CSR_COUNT_W     = 8;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ABORT_BIT  = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  function automatic logic [31:0] pack_csr(
    input logic                   active,
    input logic                   valid,
    input logic                   dup,
    input logic                   stray,
    input logic                   timeout,
    input logic [CSR_COUNT_W-1:0] count
  );
    logic [31:0] w;
    w                                 = '0;
    w[CSR_ACTIVE_BIT]                 = active;
    w[CSR_VALID_BIT]                  = valid;
    w[CSR_DUP_BIT]                    = dup;
    w[CSR_STRAY_BIT]                  = stray;
    w[CSR_TIMEOUT_BIT]                = timeout;
    w[CSR_COUNT_LSB +: CSR_COUNT_W]   = count;
    return w;
  endfunction

endpackage

// File: rtl/fmps_capture_writer_if.sv
// Bundle of CSR control, packet stream and readout port for the capture writer.
// The packet stream has no backpressure: fmpsValid is a one-cycle qualifier.
interface fmps_capture_writer_if #(
  parameter int INDEX_WIDTH = 5,
  parameter int TIMER_WIDTH = 24
);

  logic                          csrStrobe;
  logic [31:0]                   csrData;
  logic [(1<<INDEX_WIDTH)-1:0]   expectedBitmap;
  logic [TIMER_WIDTH-1:0]        intervalTicks;
  logic [INDEX_WIDTH-1:0]        fmpsIndex;
  logic [31:0]                   fmpsData;
  logic                          fmpsValid;
  logic [31:0]                   fmpsCSR;
  logic [(1<<INDEX_WIDTH)-1:0]   fmpsBitmapAll;
  logic [INDEX_WIDTH-1:0]        fmpsReadoutAddress;
  logic [31:0]                   fmpsReadout;

  modport master (
    output csrStrobe, csrData, expectedBitmap, intervalTicks,
    output fmpsIndex, fmpsData, fmpsValid, fmpsReadoutAddress,
    input  fmpsCSR, fmpsBitmapAll, fmpsReadout
  );

  modport slave (
    input  csrStrobe, csrData, expectedBitmap, intervalTicks,
    input  fmpsIndex, fmpsData, fmpsValid, fmpsReadoutAddress,
    output fmpsCSR, fmpsBitmapAll, fmpsReadout
  );

endinterface

// File: rtl/fmps_capture_dpram.sv
// Simple dual-port RAM, one write port and a read-first registered read port.
// Read latency 1 cycle; no reset and no backpressure.
module fmps_capture_dpram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [1<<ADDR_W];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_comb begin
    rd_data_d = mem_q[rd_addr];
  end

  // Non-blocking update of both keeps a same-address read returning old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fmps_capture_writer.sv
// Captures FMPS packets into RAM within a start/complete/timeout/abort interval and keeps bitmap + CSR.
// Status is registered; readout has 1-cycle latency; the packet stream is never backpressured.
module fmps_capture_writer
  import fmps_capture_pkg::*;
#(
  parameter int INDEX_WIDTH = 5,
  parameter int TIMER_WIDTH = 24
) (
  input  logic                 sysClk,
  input  logic                 sysReset,
  fmps_capture_writer_if.slave bus
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam int CNT_W = INDEX_WIDTH + 1;

  state_e                 state_q,    state_d;
  logic [DEPTH-1:0]       bitmap_q,   bitmap_d;
  logic [DEPTH-1:0]       expected_q, expected_d;
  logic [CNT_W-1:0]       count_q,    count_d;
  logic [TIMER_WIDTH-1:0] timer_q,    timer_d;
  logic                   valid_q,    valid_d;
  logic                   dup_q,      dup_d;
  logic                   stray_q,    stray_d;
  logic                   timeout_q,  timeout_d;
  logic                   rd_en_q,    rd_en_d;

  logic        start;
  logic        abort;
  logic        complete;
  logic        expire;
  logic        wr_en;
  logic [31:0] ram_rd_data;
  logic        csr_unused;

  assign csr_unused = ^bus.csrData[31:2];

  always_comb begin
    state_d    = state_q;
    bitmap_d   = bitmap_q;
    expected_d = expected_q;
    count_d    = count_q;
    timer_d    = timer_q;
    valid_d    = valid_q;
    dup_d      = dup_q;
    stray_d    = stray_q;
    timeout_d  = timeout_q;
    rd_en_d    = 1'b1;
    wr_en      = 1'b0;

    start    = bus.csrStrobe && bus.csrData[CTRL_START_BIT];
    abort    = bus.csrStrobe && bus.csrData[CTRL_ABORT_BIT] && !start;
    // Completion looks only at the registered bitmap, so the filling packet completes a cycle later.
    complete = (state_q == ST_ACTIVE) && (expected_q != '0) &&
               ((bitmap_q & expected_q) == expected_q);
    expire   = (state_q == ST_ACTIVE) && (timer_q == TIMER_WIDTH'(1));

    if (start) begin
      state_d    = ST_ACTIVE;
      bitmap_d   = '0;
      count_d    = '0;
      valid_d    = 1'b0;
      dup_d      = 1'b0;
      stray_d    = bus.fmpsValid;
      timeout_d  = 1'b0;
      expected_d = bus.expectedBitmap;
      timer_d    = bus.intervalTicks;
    end else if (state_q == ST_ACTIVE) begin
      if (timer_q != '0) begin
        timer_d = timer_q - TIMER_WIDTH'(1);
      end
      if (bus.fmpsValid) begin
        if (bitmap_q[bus.fmpsIndex]) begin
          dup_d = 1'b1;
        end else begin
          wr_en                   = 1'b1;
          bitmap_d[bus.fmpsIndex] = 1'b1;
          count_d                 = count_q + CNT_W'(1);
        end
      end
      // Priority: completion over abort over timeout.
      if (complete) begin
        state_d = ST_IDLE;
        valid_d = 1'b1;
      end else if (abort) begin
        state_d = ST_IDLE;
      end else if (expire) begin
        state_d   = ST_IDLE;
        timeout_d = 1'b1;
      end
    end else begin
      if (bus.fmpsValid) begin
        stray_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state_q    <= ST_IDLE;
      bitmap_q   <= '0;
      expected_q <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      valid_q    <= 1'b0;
      dup_q      <= 1'b0;
      stray_q    <= 1'b0;
      timeout_q  <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitmap_q   <= bitmap_d;
      expected_q <= expected_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      valid_q    <= valid_d;
      dup_q      <= dup_d;
      stray_q    <= stray_d;
      timeout_q  <= timeout_d;
      rd_en_q    <= rd_en_d;
    end
  end

  fmps_capture_dpram #(
    .ADDR_W (INDEX_WIDTH),
    .DATA_W (32)
  ) u_ram (
    .clk     (sysClk),
    .wr_en   (wr_en),
    .wr_addr (bus.fmpsIndex),
    .wr_data (bus.fmpsData),
    .rd_addr (bus.fmpsReadoutAddress),
    .rd_data (ram_rd_data)
  );

  assign bus.fmpsCSR       = pack_csr(state_q == ST_ACTIVE, valid_q, dup_q, stray_q, timeout_q,
                                      CSR_COUNT_W'(count_q));
  assign bus.fmpsBitmapAll = bitmap_q;
  // The RAM read register has no reset; hold the output at zero until it has been loaded.
  assign bus.fmpsReadout   = rd_en_q ? ram_rd_data : 32'h0;

endmodule

// File: doc/fmps_capture_writer.md
# fmps_capture_writer

Producer side of the FMPS readout path: accepts the incoming FMPS packet stream, stores each packet's 32-bit word in a dual-port RAM at its index, and maintains the presence bitmap and the acquisition CSR. The CSR and bitmap are what the readout streamer consumes. Packets are captured only inside a software-started acquisition interval. The interval ends on completion (all expected indices present), on timeout, or on abort, and this block produces exactly one readout trigger edge per interval.

## Interface
- `INDEX_WIDTH`, 5: packet index width; RAM depth and bitmap width are `1<<INDEX_WIDTH`; legal range 1..7.
- `TIMER_WIDTH`, 24: width of the interval timeout counter.

- `sysClk` in 1: single clock domain.
- `sysReset` in 1: reset, asynchronous and active-high.
- `csrStrobe` in 1: one-cycle write strobe for `csrData`.
- `csrData` in 32: bit 0 starts an interval; bit 1 aborts it; other bits are ignored.
- `expectedBitmap` in `1<<INDEX_WIDTH`: indices required for completion; sampled at start.
- `intervalTicks` in `TIMER_WIDTH`: timeout in cycles, sampled at start; 0 disables the timeout.
- `fmpsIndex` in `INDEX_WIDTH`: index of the incoming packet.
- `fmpsData` in 32: payload of the incoming packet.
- `fmpsValid` in 1: one-cycle packet qualifier.
- `fmpsCSR` out 32: status word.
  - bit 31 active; bit 30 valid (complete); bit 29 duplicate seen; bit 28 stray packet; bit 27 timed out.
  - bits [23:16] distinct-packet count, zero-extended; all other bits 0.
- `fmpsBitmapAll` out `1<<INDEX_WIDTH`: presence bitmap for the current or last interval.
- `fmpsReadoutAddress` in `INDEX_WIDTH`: RAM read address.
- `fmpsReadout` out 32: registered RAM read data.

## Operation
- States: IDLE and ACTIVE.
- Start (strobe with bit 0) in any state:
  - clears the bitmap, count, valid, duplicate, stray and timed-out flags;
  - latches `expectedBitmap`;
  - loads the timer from `intervalTicks`;
  - sets active and moves to ACTIVE.
  - A start while ACTIVE restarts the interval without producing a falling active edge.
- Abort (bit 1, bit 0 clear) in ACTIVE: active falls; valid stays 0. Abort in IDLE is a no-op. If bits 0 and 1 are both set, start wins.
- Packet in ACTIVE, bitmap bit clear: the RAM is written, the bitmap bit is set and the count increments.
- Packet in ACTIVE, bitmap bit already set: data is not written (first packet kept) and the duplicate flag is set.
- Packet in IDLE, or in the same cycle as a start: the packet is dropped and the stray flag is set. A stray in the start cycle sets stray after the clear.
- Completion: while ACTIVE, if `(bitmap & expected) == expected` and expected is non-zero, then on the same edge active falls, valid rises and the state returns to IDLE.
  - Expected = 0 never completes.
  - The packet that fills the last bit causes completion one cycle after its write.
- Timeout: the timer decrements each ACTIVE cycle when it is non-zero at load. On reaching 1 with the interval incomplete, active falls, timed-out is set, valid stays 0 and the state returns to IDLE.
- Completion and timeout in the same cycle: completion wins, so valid is 1 and timed-out is 0.
- Abort and completion in the same cycle: completion wins.
- Valid, the flags, the bitmap and the count persist in IDLE until the next start.
- Count width is `INDEX_WIDTH+1`. It cannot exceed `1<<INDEX_WIDTH`, so there is no wrap.

## Timing
- A packet accepted at edge N is reflected in the bitmap, count and RAM contents after edge N.
- Read latency is 1: address at edge N gives data on `fmpsReadout` after edge N+1.
- A read and a write to the same address in the same cycle return the old data (read-first).
- All status bits are registered; the completion decision uses the registered bitmap.
- With a timeout of T cycles, active is high for exactly T cycles after the start edge.
- Reset values: `fmpsCSR` = 0, `fmpsBitmapAll` = 0, `fmpsReadout` = 0, state IDLE, timer 0. RAM contents are not reset; they are masked by the bitmap.
- Reset asserted mid-interval drops active immediately and asynchronously.

## Structure
- Package `fmps_capture_pkg` holds:
  - CSR bit positions (ACTIVE = 31, VALID = 30, DUP = 29, STRAY = 28, TIMEOUT = 27);
  - count field low bit = 16 and control bits START = 0, ABORT = 1;
  - the state enum.
- Sub-module `fmps_capture_dpram`: simple dual-port RAM with `1<<INDEX_WIDTH` x 32 words, a write port and a registered read-first read port, no reset.

## Test plan
- Expected = 0x0000_000F, `intervalTicks` = 100, start, then packets at indices 0–3 with data 0xA0..0xA3:
  - active falls and valid rises one cycle after the index-3 write;
  - count = 4, bitmap = 0xF;
  - reads at addresses 0–3 return 0xA0..0xA3 with 1-cycle latency.
- `intervalTicks` = 10 with only index 0 sent → active high for exactly 10 cycles; then timed-out = 1, valid = 0, bitmap = 0x1.
- Index 5 sent twice (0x11 then 0x22) → RAM[5] = 0x11, duplicate = 1, count = 1.
- Packet in IDLE and packet in the start cycle → both dropped, stray = 1, bitmap = 0.
- Completion and timeout coincide (last packet timed so both fire on the same edge) → valid = 1, timed-out = 0.
- Reset asserted mid-interval, then a new start → all outputs 0 during reset; afterwards the bitmap is clear and count = 0.
